// File: rtl/ysyx_22050550_div_pkg.sv
// ysyx_22050550_div_pkg: shared width, op encodings, write-enable values and FSM states for the divider
`ifndef ysyx_22050550_CPUWIDTH
`define ysyx_22050550_CPUWIDTH 64
`endif
package ysyx_22050550_div_pkg;
  localparam int CPU_WIDTH = `ysyx_22050550_CPUWIDTH;
  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam logic WEN = 1'b1;
  localparam logic WDIS = 1'b0;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/ysyx_22050550_div_step.sv
// ysyx_22050550_div_step: one restoring shift/trial-subtract step of {rem,quo} against dvs
module ysyx_22050550_div_step
  import ysyx_22050550_div_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0] t;
  logic [WIDTH:0] d;
  always_comb begin
    t = {rem, quo[WIDTH-1]};
    d = t - {1'b0, dvs};
    rem_n = d[WIDTH] ? t[WIDTH-1:0] : d[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ~d[WIDTH]};
  end
endmodule

// File: rtl/ysyx_22050550_div_seq.sv
// ysyx_22050550_div_seq: multi-cycle RV64M divide/remainder sequencer with valid/ready in and write-back out
module ysyx_22050550_div_seq
  import ysyx_22050550_div_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic [4:0]       in_rd,
  input  logic             in_rden,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       o_rd,
  output logic             o_wen,
  output logic [WIDTH-1:0] o_wdata,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_D = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MIN_W = {{(WIDTH-31){1'b1}}, {31{1'b0}}};
  state_t state, state_n;
  logic [WIDTH-1:0] rem, quo, dvs, rem_s, quo_s;
  logic [WIDTH-1:0] a, b, ma, mb, res_s, res_c;
  logic [CW-1:0] cnt;
  logic op_rem, word, neg_q, neg_r;
  logic acc, sgn, div0, ovf;
  function automatic logic [WIDTH-1:0] ext(input logic w, input logic [WIDTH-1:0] x);
    return w ? {{(WIDTH-32){x[31]}}, x[31:0]} : x;
  endfunction
  ysyx_22050550_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem), .quo(quo), .dvs(dvs), .rem_n(rem_s), .quo_n(quo_s)
  );
  always_comb begin
    in_ready = state == IDLE && !rst;
    busy = state != IDLE;
    out_valid = state == DONE;
    acc = in_valid && in_ready && !flush;
    sgn = in_op == OP_DIV || in_op == OP_REM;
    a = in_word ? {{(WIDTH-32){sgn & in_op1[31]}}, in_op1[31:0]} : in_op1;
    b = in_word ? {{(WIDTH-32){sgn & in_op2[31]}}, in_op2[31:0]} : in_op2;
    ma = (sgn && a[WIDTH-1]) ? -a : a;
    mb = (sgn && b[WIDTH-1]) ? -b : b;
    div0 = b == '0;
    ovf = sgn && a == (in_word ? MIN_W : MIN_D) && &b;
    res_s = ext(in_word, div0 ? ((in_op == OP_REM || in_op == OP_REMU) ? a : '1)
                              : ((in_op == OP_REM) ? '0 : a));
    res_c = ext(word, op_rem ? (neg_r ? -rem_s : rem_s) : (neg_q ? -quo_s : quo_s));
    state_n = flush ? IDLE
            : state == IDLE ? (acc ? ((div0 || ovf) ? DONE : CALC) : IDLE)
            : state == CALC ? (cnt == '0 ? DONE : CALC)
            : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rd <= '0;
      o_wen <= WDIS;
      o_wdata <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      op_rem <= 1'b0;
      word <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (acc) begin
      o_rd <= in_rd;
      o_wen <= in_rden ? WEN : WDIS;
      op_rem <= in_op == OP_REM || in_op == OP_REMU;
      word <= in_word;
      neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sgn && a[WIDTH-1];
      rem <= '0;
      quo <= in_word ? ma << 32 : ma;
      dvs <= mb;
      cnt <= in_word ? CW'(31) : CW'(WIDTH-1);
      if (div0 || ovf) o_wdata <= res_s;
    end else if (state == CALC && !flush) begin
      rem <= rem_s;
      quo <= quo_s;
      cnt <= cnt - 1'b1;
      if (cnt == '0) o_wdata <= res_c;
    end
  end
endmodule

// File: tb/tb_ysyx_22050550_div_seq.sv
// tb_ysyx_22050550_div_seq: directed self-checking bench for the division sequencer
module tb_ysyx_22050550_div_seq;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_word, in_rden, flush, out_valid, out_ready, o_wen, busy;
  logic [1:0] in_op;
  logic [63:0] in_op1, in_op2, o_wdata;
  logic [4:0] in_rd, o_rd;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  ysyx_22050550_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_word(in_word), .in_op1(in_op1), .in_op2(in_op2), .in_rd(in_rd), .in_rden(in_rden),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .o_rd(o_rd), .o_wen(o_wen),
    .o_wdata(o_wdata), .busy(busy)
  );
  task automatic go(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    @(negedge clk);
    in_op = op; in_word = w; in_op1 = a; in_op2 = b; in_rd = rd; in_rden = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
  endtask
  task automatic check_op(input string name, input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat, input logic [4:0] rd);
    int n;
    go(op, w, a, b, rd);
    wait_out(n);
    vecs++;
    if (!out_valid || o_wdata !== exp) begin
      errs++;
      $display("FAIL %s data: got %h valid %b, want %h", name, o_wdata, out_valid, exp);
    end
    vecs++;
    if (n != lat) begin
      errs++;
      $display("FAIL %s latency: got %0d, want %0d", name, n, lat);
    end
    vecs++;
    if (o_rd !== rd || o_wen !== 1'b1) begin
      errs++;
      $display("FAIL %s rd/wen: got %0d/%b, want %0d/1", name, o_rd, o_wen, rd);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s after handshake: valid %b ready %b busy %b, want 0 1 0", name, out_valid, in_ready, busy);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_word = 1'b0; in_op1 = '0; in_op2 = '0; in_rd = '0; in_rden = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || o_rd !== 5'd0 || o_wen !== 1'b0 || o_wdata !== 64'd0) begin
      errs++;
      $display("FAIL reset: valid %b busy %b ready %b rd %0d wen %b wdata %h, want all 0", out_valid, busy, in_ready, o_rd, o_wen, o_wdata);
    end
    @(negedge clk) rst = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset release in_ready: got %b, want 1", in_ready);
    end
  endtask
  task automatic test_unsigned;
    check_op("divu_100_7", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65, 5'd3);
    check_op("remu_100_7", 2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 65, 5'd4);
  endtask
  task automatic test_signed;
    check_op("div_m7_2", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 5'd7);
    check_op("rem_m7_2", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 5'd8);
    check_op("rem_7_m2", 2'b10, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, 5'd9);
  endtask
  task automatic test_special;
    check_op("div_5_0", 2'b00, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 5'd10);
    check_op("remu_5_0", 2'b11, 1'b0, 64'd5, 64'd0, 64'd5, 1, 5'd11);
    check_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 5'd12);
    check_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 5'd13);
  endtask
  task automatic test_word;
    check_op("divuw_ffffffff_1", 2'b01, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 5'd14);
    check_op("divw_1_00000006_3", 2'b00, 1'b1, 64'h1_0000_0006, 64'd3, 64'd2, 33, 5'd15);
    check_op("remw_m7_2", 2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 5'd16);
  endtask
  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    go(2'b01, 1'b0, 64'd100, 64'd7, 5'd21);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vecs++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || o_wdata !== 64'd14 || o_rd !== 5'd21) begin
        errs++;
        $display("FAIL backpressure hold %0d: valid %b busy %b wdata %h rd %0d, want 1 1 e 21", i, out_valid, busy, o_wdata, o_rd);
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL backpressure release: valid %b ready %b, want 0 1", out_valid, in_ready);
    end
  endtask
  task automatic test_flush;
    logic seen;
    go(2'b01, 1'b0, 64'd100, 64'd7, 5'd22);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    vecs++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush calc: busy %b ready %b valid %b, want 0 1 0", busy, in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1 seen |= out_valid;
    end
    vecs++;
    if (seen !== 1'b0) begin
      errs++;
      $display("FAIL flush no result: out_valid seen %b, want 0", seen);
    end
    @(negedge clk);
    in_op = 2'b01; in_word = 1'b0; in_op1 = 64'd9; in_op2 = 64'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    vecs++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush idle accept: busy %b valid %b, want 0 0", busy, out_valid);
    end
  endtask
  task automatic test_rst_mid;
    go(2'b01, 1'b0, 64'd100, 64'd7, 5'd23);
    repeat (20) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || o_rd !== 5'd0 || o_wen !== 1'b0 || o_wdata !== 64'd0) begin
      errs++;
      $display("FAIL rst mid calc: valid %b busy %b ready %b rd %0d wen %b wdata %h, want all 0", out_valid, busy, in_ready, o_rd, o_wen, o_wdata);
    end
    @(negedge clk) rst = 1'b0;
  endtask
  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_special;
    test_word;
    test_backpressure;
    test_flush;
    test_rst_mid;
    check_op("divu_after_rst", 2'b01, 1'b0, 64'd1000, 64'd10, 64'd100, 65, 5'd31);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
